// File: rtl/copperv_pkg.sv
// Shared writeback types: register addresses, data words, queued result entries and source ids.
package copperv_pkg;
  localparam int WORD_W = 32;

  typedef logic [4:0]        reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  typedef enum logic {WB_ALU = 1'b0, WB_LD = 1'b1} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; a push is still taken when full if a pop frees a slot that cycle.
module wb_fifo
  import copperv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  entry_t                   wr_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end
endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: round-robin between ALU results and queued loads, one registered regfile
// write per cycle, plus a pending-write scoreboard for RAW stall detection at issue.
module rf_writeback
  import copperv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  reg_addr_t       alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  reg_addr_t       ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_en,
  input  reg_addr_t       issue_rd,
  input  reg_addr_t       rs1,
  input  reg_addr_t       rs2,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output reg_addr_t       rf_rd,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            rf_rd_en
);
  localparam int LAW = $clog2(LD_DEPTH);

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t       ld_entry;
  entry_t       ld_head;
  entry_t       win;
  logic         ld_full;
  logic         ld_empty;
  logic [LAW:0] ld_count;
  logic         ld_push;
  wb_src_e      rr_last;
  logic         grant_alu;
  logic         grant_ld;
  logic         grant;
  logic [31:0]  pending;
  logic [31:0]  set_mask;
  logic [31:0]  clr_mask;

  assign ld_entry = entry_t'{rd: ld_rd, data: ld_data};
  assign ld_ready = !ld_full;
  assign ld_push  = ld_valid && ld_ready;

  wb_fifo #(
    .DEPTH   (LD_DEPTH),
    .entry_t (entry_t)
  ) u_ld_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (ld_push),
    .wr_entry (ld_entry),
    .pop      (grant_ld),
    .head     (ld_head),
    .full     (ld_full),
    .empty    (ld_empty),
    .count    (ld_count)
  );

  // Grants are suppressed while in reset so the ALU is never told its result was taken
  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (rstn) begin
      if (alu_valid && !ld_empty) begin
        if (rr_last == WB_ALU) grant_ld  = 1'b1;
        else                   grant_alu = 1'b1;
      end else if (alu_valid) begin
        grant_alu = 1'b1;
      end else if (!ld_empty) begin
        grant_ld = 1'b1;
      end
    end
  end

  assign grant     = grant_alu || grant_ld;
  assign alu_ready = grant_alu;
  assign win       = grant_ld ? ld_head : entry_t'{rd: alu_rd, data: alu_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last    <= WB_ALU;
      rf_rd      <= '0;
      rf_rd_data <= '0;
      rf_rd_en   <= 1'b0;
    end else begin
      if (grant) begin
        rr_last    <= grant_ld ? WB_LD : WB_ALU;
        rf_rd      <= win.rd;
        rf_rd_data <= win.data;
        rf_rd_en   <= (win.rd != '0);
      end else begin
        rf_rd_en   <= 1'b0;
      end
    end
  end

  // Set wins over clear so a same-cycle re-issue of rd keeps the newer write pending
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (grant && (win.rd != '0))          clr_mask[win.rd]   = 1'b1;
    if (issue_en && (issue_rd != '0))     set_mask[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  assign rs1_pending = (rs1 != '0) && pending[rs1];
  assign rs2_pending = (rs2 != '0) && pending[rs2];

  assert property (@(posedge clk) disable iff (!rstn) ld_count <= (LAW+1)'(LD_DEPTH));
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based reference model of the writeback rules.
module tb_rf_writeback;
  localparam int XLEN     = 32;
  localparam int LD_DEPTH = 2;

  logic            clk;
  logic            rstn;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            issue_en;
  logic [4:0]      issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_pending;
  logic            rs2_pending;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_rd_data;
  logic            rf_rd_en;

  rf_writeback #(.XLEN(XLEN), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .rf_rd_en(rf_rd_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        lq[$];
  bit          last_ld;
  bit          pend[32];
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_en;
  bit          m_ld_acc;
  logic [31:0] dut_log[$];
  logic        obs_ld_ready;
  logic        obs_rs1p;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          exp_en;
  } alu_vec_t;
  alu_vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_en = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic model_reset();
    lq.delete();
    last_ld = 0;
    foreach (pend[i]) pend[i] = 0;
    m_rd = 0; m_data = 0; m_en = 0;
    dut_log.delete();
  endtask

  // Entered and left at posedge+1; reset is asserted away from the clock edge
  task automatic do_reset();
    alu_valid = 1'b1;
    rstn = 1'b0;
    #1;
    chk("rst_rf_rd_en", rf_rd_en, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_rd_data", rf_rd_data, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 0);
    for (int r = 0; r < 32; r++) begin
      rs1 = r[4:0];
      #1;
      chk("rst_rs1_pending", rs1_pending, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rf_rd_en", rf_rd_en, 0);
    clear_inputs();
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus: inputs are already driven; checks comb outputs, then registered ones
  task automatic cycle();
    int   win;
    ent_t w;
    bit   e_ldr;
    #1;
    e_ldr = (lq.size() < LD_DEPTH);
    if (alu_valid && lq.size() > 0) win = last_ld ? 1 : 2;
    else if (alu_valid)             win = 1;
    else if (lq.size() > 0)         win = 2;
    else                            win = 0;
    chk("alu_ready", alu_ready, (win == 1));
    chk("ld_ready", ld_ready, e_ldr);
    chk("rs1_pending", rs1_pending, (rs1 != 0) && pend[rs1]);
    chk("rs2_pending", rs2_pending, (rs2 != 0) && pend[rs2]);
    obs_ld_ready = ld_ready;
    obs_rs1p     = rs1_pending;
    m_ld_acc     = ld_valid && e_ldr;
    w.rd = 0; w.data = 0;
    if (win == 1) begin
      w.rd = alu_rd; w.data = alu_data; last_ld = 0;
    end else if (win == 2) begin
      w = lq.pop_front(); last_ld = 1;
    end
    if (m_ld_acc) lq.push_back('{rd: ld_rd, data: ld_data});
    if (win != 0) begin
      m_rd = w.rd; m_data = w.data; m_en = (w.rd != 0);
      if (w.rd != 0) pend[w.rd] = 0;
    end else begin
      m_en = 0;
    end
    if (issue_en && issue_rd != 0) pend[issue_rd] = 1;
    @(posedge clk);
    #1;
    chk("rf_rd_en", rf_rd_en, m_en);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_rd_data", rf_rd_data, m_data);
    if (rf_rd_en) dut_log.push_back(rf_rd_data);
  endtask

  initial begin
    int li;
    int nld;
    bit exp_rdy[4];

    tbl[0] = '{rd: 5'd5,  data: 32'hDEADBEEF, exp_en: 1'b1};
    tbl[1] = '{rd: 5'd0,  data: 32'h12345678, exp_en: 1'b0};
    tbl[2] = '{rd: 5'd31, data: 32'hFFFFFFFF, exp_en: 1'b1};
    tbl[3] = '{rd: 5'd1,  data: 32'h00000000, exp_en: 1'b1};

    clear_inputs();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single ALU results from idle: accept, write next cycle, idle after, data held
    foreach (tbl[i]) begin
      alu_valid = 1; alu_rd = tbl[i].rd; alu_data = tbl[i].data;
      #1;
      chk("tbl_alu_ready", alu_ready, 1);
      @(posedge clk);
      #1;
      alu_valid = 0;
      chk("tbl_rf_rd_en", rf_rd_en, tbl[i].exp_en);
      if (tbl[i].exp_en) begin
        chk("tbl_rf_rd", rf_rd, tbl[i].rd);
        chk("tbl_rf_rd_data", rf_rd_data, tbl[i].data);
      end
      @(posedge clk);
      #1;
      chk("tbl_idle_rf_rd_en", rf_rd_en, 0);
      if (tbl[i].exp_en) begin
        chk("tbl_hold_rf_rd", rf_rd, tbl[i].rd);
        chk("tbl_hold_rf_rd_data", rf_rd_data, tbl[i].data);
      end
    end
    do_reset();

    // Contention: both sources every cycle -> ALU first (queue empty), then strict alternation
    for (int k = 0; k < 12; k++) begin
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'hA0000000 + k;
      ld_valid = 1;  ld_rd = 5'd2;  ld_data = 32'hB0000000 + k;
      cycle();
      chk("cont_en", rf_rd_en, 1);
      chk("cont_rd", rf_rd, (k % 2 == 0) ? 5'd1 : 5'd2);
    end
    clear_inputs();
    repeat (4) cycle();
    do_reset();

    // Load queue fills while the ALU keeps competing; loads must drain in order
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    li = 0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA0000000 + c;
      ld_valid = (li < 3); ld_rd = 5'd10 + li[4:0]; ld_data = 32'h10000000 + li;
      cycle();
      if (c < 4) chk("full_ld_ready", obs_ld_ready, exp_rdy[c]);
      if (m_ld_acc) li++;
      if (li == 3 && c >= 4) break;
    end
    chk("full_all_pushed", li, 3);
    clear_inputs();
    repeat (6) cycle();
    nld = 0;
    foreach (dut_log[i]) begin
      if (dut_log[i][31:28] == 4'h1) begin
        chk("full_load_order", dut_log[i], 32'h10000000 + nld);
        nld++;
      end
    end
    chk("full_load_count", nld, 3);
    do_reset();

    // Scoreboard: set, same-cycle set+clear keeps pending, a second write clears
    rs1 = 5'd7; rs2 = 5'd0;
    issue_en = 1; issue_rd = 5'd7;
    cycle();
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h1;
    cycle();
    chk("sb_set", obs_rs1p, 1);
    issue_en = 0;
    alu_data = 32'h2;
    cycle();
    chk("sb_same_cycle_keeps", obs_rs1p, 1);
    alu_valid = 0;
    cycle();
    chk("sb_cleared", obs_rs1p, 0);
    chk("sb_x0", rs2_pending, 0);
    do_reset();

    // Random traffic against the model, with a reset dropped mid-stream
    for (int n = 0; n < 400; n++) begin
      alu_valid = $urandom_range(0, 1);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = $urandom_range(0, 1);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      issue_en  = $urandom_range(0, 1);
      issue_rd  = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end
    do_reset();
    for (int n = 0; n < 60; n++) begin
      alu_valid = $urandom_range(0, 1);
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_valid  = $urandom_range(0, 1);
      ld_rd     = 5'($urandom_range(0, 7));
      ld_data   = $urandom;
      issue_en  = $urandom_range(0, 1);
      issue_rd  = 5'($urandom_range(0, 7));
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
